sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_addr_counter.sv | 78 +++++++
 rtl/sram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and width constants for the SRAM arbiter slice.
// Holds the access-sequencer state encoding and the default bus widths.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 8;
    localparam int LD_BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WHOLD,
        READ,
        RCAP,
        INC
    } state_t;

endpackage

// File: rtl/sram_addr_counter.sv
// SRAM address counter with byte-wise shadow loading and FULL/EMPTY flags.
// Shadow bytes wait in pending flags until the sequencer is idle and applies them.
module sram_addr_counter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ld_l,
    input  logic                 i_ld_h,
    input  logic                 i_ld_u,
    input  logic [LD_BYTE_W-1:0] i_ld_data,
    input  logic                 i_apply,
    input  logic                 i_inc,
    input  logic                 i_inc_write,
    output logic [ADDR_W-1:0]    o_count,
    output logic                 o_ld_pending,
    output logic                 o_empty,
    output logic                 o_full
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [LD_BYTE_W-1:0] r_shadow_l;
    logic [LD_BYTE_W-1:0] r_shadow_h;
    logic [ADDR_W-17:0]   r_shadow_u;
    logic [2:0]           r_ld_pend;
    logic [ADDR_W-1:0]    r_count;
    logic                 r_empty;
    logic                 r_full;
    logic [ADDR_W-1:0]    w_count_next;
    logic                 w_at_max;

    assign w_at_max = &r_count;

    // Only the bytes that were actually loaded overwrite the counter.
    always_comb begin
        w_count_next = r_count;
        if (i_apply) begin
            if (r_ld_pend[0]) w_count_next[7:0]         = r_shadow_l;
            if (r_ld_pend[1]) w_count_next[15:8]        = r_shadow_h;
            if (r_ld_pend[2]) w_count_next[ADDR_W-1:16] = r_shadow_u;
        end else if (i_inc && !w_at_max) begin
            w_count_next = r_count + ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow_l <= '0;
            r_shadow_h <= '0;
            r_shadow_u <= '0;
            r_ld_pend  <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            if (i_ld_l) r_shadow_l <= i_ld_data;
            if (i_ld_h) r_shadow_h <= i_ld_data;
            if (i_ld_u) r_shadow_u <= i_ld_data[ADDR_W-17:0];
            r_ld_pend <= (r_ld_pend & ~{3{i_apply}}) | {i_ld_u, i_ld_h, i_ld_l};
            if (i_apply) begin
                r_full <= 1'b0;
            end else if (i_inc && w_at_max && i_inc_write) begin
                r_full <= 1'b1;
            end
        end
    end

    assign o_count      = r_count;
    assign o_ld_pending = |r_ld_pend;
    assign o_empty      = r_empty;
    assign o_full       = r_full;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates acquisition writes, MCU writes and MCU reads onto one async SRAM.
// Each requester owns a single pending slot; the sequencer serves them by fixed priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 CLOCK,
    input  logic                 RESET_n,
    input  logic                 ACQ_WR_REQ,
    input  logic [DATA_W-1:0]    ACQ_WR_DATA,
    input  logic                 MCU_WR_REQ,
    input  logic [DATA_W-1:0]    MCU_WR_DATA,
    input  logic                 MCU_RD_REQ,
    output logic [DATA_W-1:0]    MCU_RD_DATA,
    output logic                 MCU_RD_VALID,
    input  logic                 ADDR_LD_L,
    input  logic                 ADDR_LD_H,
    input  logic                 ADDR_LD_U,
    input  logic [LD_BYTE_W-1:0] ADDR_LD_DATA,
    input  logic                 CLR_OVERRUN,
    output logic [ADDR_W-1:0]    SRAM_A,
    output logic [DATA_W-1:0]    SRAM_DQ_OUT,
    input  logic [DATA_W-1:0]    SRAM_DQ_IN,
    output logic                 SRAM_DQ_OE,
    output logic                 SRAM_WE_n,
    output logic                 SRAM_OE_n,
    output logic                 BUSY,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic                 ACQ_OVERRUN
);

    state_t              r_state;
    logic                r_acq_pend;
    logic [DATA_W-1:0]   r_acq_data;
    logic                r_mcuw_pend;
    logic [DATA_W-1:0]   r_mcuw_data;
    logic                r_mcur_pend;
    logic                r_acc_write;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_we_n;
    logic                r_oe_n;
    logic                r_dq_oe;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_overrun;

    logic                w_ld_pending;
    logic                w_full;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_count;
    logic                w_idle;
    logic                w_apply;
    logic                w_grant_acq;
    logic                w_grant_mcuw;
    logic                w_grant_mcur;

    assign w_idle       = (r_state == IDLE);
    assign w_apply      = w_idle && w_ld_pending;
    assign w_grant_acq  = w_idle && !w_ld_pending && r_acq_pend;
    assign w_grant_mcuw = w_idle && !w_ld_pending && !r_acq_pend && r_mcuw_pend;
    assign w_grant_mcur = w_idle && !w_ld_pending && !r_acq_pend && !r_mcuw_pend && r_mcur_pend;

    sram_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
        .i_clk        (CLOCK),
        .i_rst_n      (RESET_n),
        .i_ld_l       (ADDR_LD_L),
        .i_ld_h       (ADDR_LD_H),
        .i_ld_u       (ADDR_LD_U),
        .i_ld_data    (ADDR_LD_DATA),
        .i_apply      (w_apply),
        .i_inc        (r_state == INC),
        .i_inc_write  (r_acc_write),
        .o_count      (w_count),
        .o_ld_pending (w_ld_pending),
        .o_empty      (w_empty),
        .o_full       (w_full)
    );

    // A strobe that finds its slot occupied is lost, even if the slot is granted that cycle.
    always_ff @(posedge CLOCK) begin
        if (!RESET_n) begin
            r_acq_pend  <= 1'b0;
            r_acq_data  <= '0;
            r_mcuw_pend <= 1'b0;
            r_mcuw_data <= '0;
            r_mcur_pend <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (ACQ_WR_REQ && !r_acq_pend) begin
                r_acq_pend <= 1'b1;
                r_acq_data <= ACQ_WR_DATA;
            end else if (w_grant_acq) begin
                r_acq_pend <= 1'b0;
            end
            if (MCU_WR_REQ && !r_mcuw_pend) begin
                r_mcuw_pend <= 1'b1;
                r_mcuw_data <= MCU_WR_DATA;
            end else if (w_grant_mcuw) begin
                r_mcuw_pend <= 1'b0;
            end
            if (MCU_RD_REQ && !r_mcur_pend) begin
                r_mcur_pend <= 1'b1;
            end else if (w_grant_mcur) begin
                r_mcur_pend <= 1'b0;
            end
            if ((ACQ_WR_REQ && r_acq_pend) || (w_grant_acq && w_full)) begin
                r_overrun <= 1'b1;
            end else if (CLR_OVERRUN) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Pad controls are set on entry to each state so they come straight from flops.
    always_ff @(posedge CLOCK) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_acc_write <= 1'b0;
            r_wr_data   <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_acq || w_grant_mcuw) begin
                        r_acc_write <= 1'b1;
                        if (!w_full) begin
                            r_state   <= WRITE;
                            r_we_n    <= 1'b0;
                            r_dq_oe   <= 1'b1;
                            r_wr_data <= w_grant_acq ? r_acq_data : r_mcuw_data;
                        end
                    end else if (w_grant_mcur) begin
                        r_acc_write <= 1'b0;
                        r_state     <= READ;
                        r_oe_n      <= 1'b0;
                    end
                end
                WRITE: begin
                    r_state <= WHOLD;
                    r_we_n  <= 1'b1;
                end
                WHOLD: begin
                    r_state <= INC;
                    r_dq_oe <= 1'b0;
                end
                READ: begin
                    r_state <= RCAP;
                end
                RCAP: begin
                    r_state    <= INC;
                    r_oe_n     <= 1'b1;
                    r_rd_data  <= SRAM_DQ_IN;
                    r_rd_valid <= 1'b1;
                end
                INC: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign SRAM_A       = w_count;
    assign SRAM_DQ_OUT  = r_wr_data;
    assign SRAM_DQ_OE   = r_dq_oe;
    assign SRAM_WE_n    = r_we_n;
    assign SRAM_OE_n    = r_oe_n;
    assign MCU_RD_DATA  = r_rd_data;
    assign MCU_RD_VALID = r_rd_valid;
    assign BUSY         = !w_idle || r_acq_pend || r_mcuw_pend || r_mcur_pend || w_ld_pending;
    assign EMPTY        = w_empty;
    assign FULL         = w_full;
    assign ACQ_OVERRUN  = r_overrun;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of counter, flags and SRAM contents.
module tb_sram_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam logic [18:0] MAX_ADDR = 19'h7FFFF;

    logic              CLOCK = 1'b0;
    logic              RESET_n;
    logic              ACQ_WR_REQ;
    logic [7:0]        ACQ_WR_DATA;
    logic              MCU_WR_REQ;
    logic [7:0]        MCU_WR_DATA;
    logic              MCU_RD_REQ;
    logic [7:0]        MCU_RD_DATA;
    logic              MCU_RD_VALID;
    logic              ADDR_LD_L;
    logic              ADDR_LD_H;
    logic              ADDR_LD_U;
    logic [7:0]        ADDR_LD_DATA;
    logic              CLR_OVERRUN;
    logic [18:0]       SRAM_A;
    logic [7:0]        SRAM_DQ_OUT;
    logic [7:0]        SRAM_DQ_IN = 8'h00;
    logic              SRAM_DQ_OE;
    logic              SRAM_WE_n;
    logic              SRAM_OE_n;
    logic              BUSY;
    logic              EMPTY;
    logic              FULL;
    logic              ACQ_OVERRUN;

    int testsRun = 0;
    int failCount = 0;
    int weLowCount = 0;
    int overlapCount = 0;

    logic [26:0] obsWrites[$];
    logic [26:0] expWrites[$];
    logic [7:0]  obsReads[$];
    logic [7:0]  expReads[$];
    logic [7:0]  sramMem [logic [18:0]];
    logic [7:0]  refMem  [logic [18:0]];

    logic [18:0] modelCounter;
    bit          modelFull;
    bit          modelOverrun;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLOCK        (CLOCK),
        .RESET_n      (RESET_n),
        .ACQ_WR_REQ   (ACQ_WR_REQ),
        .ACQ_WR_DATA  (ACQ_WR_DATA),
        .MCU_WR_REQ   (MCU_WR_REQ),
        .MCU_WR_DATA  (MCU_WR_DATA),
        .MCU_RD_REQ   (MCU_RD_REQ),
        .MCU_RD_DATA  (MCU_RD_DATA),
        .MCU_RD_VALID (MCU_RD_VALID),
        .ADDR_LD_L    (ADDR_LD_L),
        .ADDR_LD_H    (ADDR_LD_H),
        .ADDR_LD_U    (ADDR_LD_U),
        .ADDR_LD_DATA (ADDR_LD_DATA),
        .CLR_OVERRUN  (CLR_OVERRUN),
        .SRAM_A       (SRAM_A),
        .SRAM_DQ_OUT  (SRAM_DQ_OUT),
        .SRAM_DQ_IN   (SRAM_DQ_IN),
        .SRAM_DQ_OE   (SRAM_DQ_OE),
        .SRAM_WE_n    (SRAM_WE_n),
        .SRAM_OE_n    (SRAM_OE_n),
        .BUSY         (BUSY),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ACQ_OVERRUN  (ACQ_OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [7:0] defaultByte(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // SRAM pad model and bus monitor, sampled mid-cycle
    always @(negedge CLOCK) begin
        if (SRAM_WE_n === 1'b0) begin
            weLowCount++;
            obsWrites.push_back({SRAM_A, SRAM_DQ_OUT});
            sramMem[SRAM_A] = SRAM_DQ_OUT;
        end
        if (SRAM_DQ_OE === 1'b1 && SRAM_OE_n === 1'b0) overlapCount++;
        if (MCU_RD_VALID === 1'b1) obsReads.push_back(MCU_RD_DATA);
        if (SRAM_OE_n === 1'b0)
            SRAM_DQ_IN = sramMem.exists(SRAM_A) ? sramMem[SRAM_A] : defaultByte(SRAM_A);
        else
            SRAM_DQ_IN = 8'h00;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic acq, input logic [7:0] acqData,
                                 input logic mcuw, input logic [7:0] mcuwData,
                                 input logic mcur, input logic [2:0] ld,
                                 input logic [7:0] ldData, input logic clr);
        ACQ_WR_REQ   = acq;
        ACQ_WR_DATA  = acqData;
        MCU_WR_REQ   = mcuw;
        MCU_WR_DATA  = mcuwData;
        MCU_RD_REQ   = mcur;
        ADDR_LD_L    = ld[0];
        ADDR_LD_H    = ld[1];
        ADDR_LD_U    = ld[2];
        ADDR_LD_DATA = ldData;
        CLR_OVERRUN  = clr;
        tick();
        ACQ_WR_REQ   = 1'b0;
        MCU_WR_REQ   = 1'b0;
        MCU_RD_REQ   = 1'b0;
        ADDR_LD_L    = 1'b0;
        ADDR_LD_H    = 1'b0;
        ADDR_LD_U    = 1'b0;
        CLR_OVERRUN  = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (BUSY !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("idle_wait", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic modelReset();
        modelCounter = '0;
        modelFull    = 1'b0;
        modelOverrun = 1'b0;
    endtask

    task automatic modelWrite(input logic [7:0] d, input bit isAcq);
        if (modelFull) begin
            if (isAcq) modelOverrun = 1'b1;
        end else begin
            expWrites.push_back({modelCounter, d});
            refMem[modelCounter] = d;
            if (modelCounter == MAX_ADDR) modelFull = 1'b1;
            else modelCounter = modelCounter + 19'd1;
        end
    endtask

    task automatic modelRead();
        expReads.push_back(refMem.exists(modelCounter) ? refMem[modelCounter] : defaultByte(modelCounter));
        if (modelCounter != MAX_ADDR) modelCounter = modelCounter + 19'd1;
    endtask

    // Upper address byte carries junk in its unused bits on purpose
    task automatic loadAddr(input logic [18:0] a);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 3'b001, a[7:0], 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 3'b010, a[15:8], 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 3'b100, {5'b10101, a[18:16]}, 0);
        waitIdle(20);
        modelCounter = a;
        modelFull    = 1'b0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_addr"}, {13'd0, SRAM_A}, {13'd0, modelCounter});
        checkOutput({tag, "_full"}, {31'd0, FULL}, {31'd0, modelFull});
        checkOutput({tag, "_empty"}, {31'd0, EMPTY}, {31'd0, (modelCounter == 19'd0)});
        checkOutput({tag, "_overrun"}, {31'd0, ACQ_OVERRUN}, {31'd0, modelOverrun});
    endtask

    task automatic compareLogs(input string tag);
        checkOutput({tag, "_nwrites"}, obsWrites.size(), expWrites.size());
        while (obsWrites.size() > 0 && expWrites.size() > 0)
            checkOutput({tag, "_write"}, {5'd0, obsWrites.pop_front()}, {5'd0, expWrites.pop_front()});
        obsWrites.delete();
        expWrites.delete();
        checkOutput({tag, "_nreads"}, obsReads.size(), expReads.size());
        while (obsReads.size() > 0 && expReads.size() > 0)
            checkOutput({tag, "_read"}, {24'd0, obsReads.pop_front()}, {24'd0, expReads.pop_front()});
        obsReads.delete();
        expReads.delete();
    endtask

    initial begin
        int weBefore;
        logic [7:0] d;
        logic [18:0] a;
        int op;

        RESET_n      = 1'b0;
        ACQ_WR_REQ   = 1'b0;
        ACQ_WR_DATA  = 8'h00;
        MCU_WR_REQ   = 1'b0;
        MCU_WR_DATA  = 8'h00;
        MCU_RD_REQ   = 1'b0;
        ADDR_LD_L    = 1'b0;
        ADDR_LD_H    = 1'b0;
        ADDR_LD_U    = 1'b0;
        ADDR_LD_DATA = 8'h00;
        CLR_OVERRUN  = 1'b0;
        modelReset();
        repeat (3) tick();

        checkOutput("rst_we_n", {31'd0, SRAM_WE_n}, 32'd1);
        checkOutput("rst_oe_n", {31'd0, SRAM_OE_n}, 32'd1);
        checkOutput("rst_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
        checkOutput("rst_rd_valid", {31'd0, MCU_RD_VALID}, 32'd0);
        checkOutput("rst_rd_data", {24'd0, MCU_RD_DATA}, 32'd0);
        checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
        checkState("rst");
        RESET_n = 1'b1;
        tick();

        $display("[TB] load 0x00010 and MCU write 0xA5");
        loadAddr(19'h00010);
        checkState("load10");
        applyStimulus(0, 8'h00, 1, 8'hA5, 0, 3'b000, 8'h00, 0);
        checkOutput("we_not_yet", {31'd0, SRAM_WE_n}, 32'd1);
        tick();
        checkOutput("we_low", {31'd0, SRAM_WE_n}, 32'd0);
        checkOutput("we_addr", {13'd0, SRAM_A}, 32'h10);
        checkOutput("we_data", {24'd0, SRAM_DQ_OUT}, 32'hA5);
        checkOutput("we_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd1);
        tick();
        checkOutput("whold_we_n", {31'd0, SRAM_WE_n}, 32'd1);
        checkOutput("whold_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd1);
        checkOutput("whold_addr", {13'd0, SRAM_A}, 32'h10);
        waitIdle(20);
        modelWrite(8'hA5, 0);
        checkState("wrA5");
        compareLogs("wrA5");

        $display("[TB] simultaneous ACQ and MCU writes");
        applyStimulus(1, 8'h11, 1, 8'h22, 0, 3'b000, 8'h00, 0);
        waitIdle(30);
        modelWrite(8'h11, 1);
        modelWrite(8'h22, 0);
        checkState("prio");
        compareLogs("prio");

        $display("[TB] ACQ overrun while slot pending");
        applyStimulus(0, 8'h00, 1, 8'h31, 0, 3'b000, 8'h00, 0);
        tick();
        applyStimulus(1, 8'h41, 0, 8'h00, 0, 3'b000, 8'h00, 0);
        applyStimulus(1, 8'h42, 0, 8'h00, 0, 3'b000, 8'h00, 0);
        waitIdle(30);
        modelWrite(8'h31, 0);
        modelWrite(8'h41, 1);
        modelOverrun = 1'b1;
        checkState("ovr");
        compareLogs("ovr");
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 1);
        modelOverrun = 1'b0;
        checkState("ovr_clr");

        applyStimulus(0, 8'h00, 1, 8'h32, 0, 3'b000, 8'h00, 0);
        tick();
        applyStimulus(1, 8'h43, 0, 8'h00, 0, 3'b000, 8'h00, 0);
        applyStimulus(1, 8'h44, 0, 8'h00, 0, 3'b000, 8'h00, 1);
        checkOutput("set_wins", {31'd0, ACQ_OVERRUN}, 32'd1);
        waitIdle(30);
        modelWrite(8'h32, 0);
        modelWrite(8'h43, 1);
        modelOverrun = 1'b1;
        checkState("setwin");
        compareLogs("setwin");
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 1);
        modelOverrun = 1'b0;

        $display("[TB] saturation at the top address");
        loadAddr(MAX_ADDR);
        checkState("ldmax");
        applyStimulus(1, 8'h77, 0, 8'h00, 0, 3'b000, 8'h00, 0);
        waitIdle(20);
        modelWrite(8'h77, 1);
        checkState("wrmax");
        weBefore = weLowCount;
        applyStimulus(1, 8'h78, 0, 8'h00, 0, 3'b000, 8'h00, 0);
        waitIdle(20);
        modelWrite(8'h78, 1);
        checkOutput("full_no_we", weLowCount - weBefore, 32'd0);
        checkState("fullacq");
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 1);
        modelOverrun = 1'b0;
        applyStimulus(0, 8'h00, 1, 8'h79, 0, 3'b000, 8'h00, 0);
        waitIdle(20);
        modelWrite(8'h79, 0);
        checkState("fullmcu");
        compareLogs("full");
        loadAddr(19'h00005);
        checkState("unfull");

        $display("[TB] MCU read at 0x00005");
        sramMem[19'h00005] = 8'h3C;
        refMem[19'h00005]  = 8'h3C;
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 3'b000, 8'h00, 0);
        tick();
        tick();
        checkOutput("rcap_oe_n", {31'd0, SRAM_OE_n}, 32'd0);
        checkOutput("rcap_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
        tick();
        checkOutput("rd_valid", {31'd0, MCU_RD_VALID}, 32'd1);
        checkOutput("rd_data", {24'd0, MCU_RD_DATA}, 32'h3C);
        checkOutput("inc_oe_n", {31'd0, SRAM_OE_n}, 32'd1);
        tick();
        checkOutput("rd_valid_drop", {31'd0, MCU_RD_VALID}, 32'd0);
        waitIdle(20);
        modelRead();
        checkState("rd5");
        compareLogs("rd5");

        $display("[TB] reset during WRITE");
        applyStimulus(1, 8'h55, 1, 8'h66, 0, 3'b000, 8'h00, 0);
        tick();
        checkOutput("pre_rst_we", {31'd0, SRAM_WE_n}, 32'd0);
        RESET_n = 1'b0;
        tick();
        RESET_n = 1'b1;
        modelWrite(8'h55, 1);
        modelReset();
        checkOutput("midrst_we_n", {31'd0, SRAM_WE_n}, 32'd1);
        checkOutput("midrst_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
        checkOutput("midrst_busy", {31'd0, BUSY}, 32'd0);
        checkState("midrst");
        weBefore = weLowCount;
        repeat (8) tick();
        checkOutput("midrst_no_we", weLowCount - weBefore, 32'd0);
        compareLogs("midrst");

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 10);
            d  = 8'($urandom);
            if (op <= 1) begin
                a = ($urandom_range(0, 1) == 0) ? 19'($urandom) : (MAX_ADDR - 19'($urandom_range(0, 3)));
                if ($urandom_range(0, 7) == 0) a = 19'd0;
                loadAddr(a);
            end else if (op <= 4) begin
                applyStimulus(1, d, 0, 8'h00, 0, 3'b000, 8'h00, 0);
                waitIdle(20);
                modelWrite(d, 1);
            end else if (op <= 6) begin
                applyStimulus(0, 8'h00, 1, d, 0, 3'b000, 8'h00, 0);
                waitIdle(20);
                modelWrite(d, 0);
            end else if (op <= 9) begin
                applyStimulus(0, 8'h00, 0, 8'h00, 1, 3'b000, 8'h00, 0);
                waitIdle(20);
                modelRead();
            end else begin
                applyStimulus(0, 8'h00, 0, 8'h00, 0, 3'b000, 8'h00, 1);
                modelOverrun = 1'b0;
            end
            checkState("rand");
        end
        compareLogs("rand");

        checkOutput("dq_oe_overlap", overlapCount, 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
